// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite definitions: bus encodings, SRAM slave FSM states and byte-lane helpers.
package ahb3lite_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;
  localparam logic [2:0] HSIZE_B128  = 3'b100;
  localparam logic [2:0] HSIZE_B256  = 3'b101;
  localparam logic [2:0] HSIZE_B512  = 3'b110;
  localparam logic [2:0] HSIZE_B1024 = 3'b111;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest supported data bus is 1024 bits, i.e. 128 byte lanes
  localparam int MAX_BE_BITS = 128;

  // Data-phase states of the SRAM slaves
  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    RDATA,
    ERR1,
    ERR2
  } sram_state_e;

  // Number of bytes moved by a transfer of the given HSIZE
  function automatic int size_bytes(input logic [2:0] hsize);
    return 1 << hsize;
  endfunction

  // Byte-lane mask for a transfer: a run of size_bytes lanes starting at the
  // size-aligned byte offset. Callers truncate to their own lane count.
  function automatic logic [MAX_BE_BITS-1:0] gen_be(input logic [2:0]  hsize,
                                                     input logic [31:0] offset);
    logic [MAX_BE_BITS-1:0] be;
    logic [31:0]            nbytes;
    logic [31:0]            base;
    nbytes = 32'(size_bytes(hsize));
    base   = offset & ~(nbytes - 32'd1);
    be     = '0;
    for (int i = 0; i < MAX_BE_BITS; i++) begin
      be[i] = (32'(i) >= base) && (32'(i) < base + nbytes);
    end
    return be;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// Two-port storage: one synchronous read port, one byte-enabled write port.
// A read of the word being written in the same cycle returns the old contents.
module rl_ram_1r1w #(
  parameter int    ABITS      = 8,
  parameter int    DBITS      = 32,
  parameter string TECHNOLOGY = "GENERIC"
) (
  input  logic                 clk_i,
  input  logic [ABITS-1:0]     waddr_i,
  input  logic                 we_i,
  input  logic [DBITS/8-1:0]   be_i,
  input  logic [DBITS-1:0]     din_i,
  input  logic [ABITS-1:0]     raddr_i,
  output logic [DBITS-1:0]     dout_o
);

  localparam int BYTES = DBITS / 8;
  localparam int DEPTH = 2 ** ABITS;

  // Only the behavioural model exists today; a vendor macro would be chosen on this
  localparam bit unusedTechGeneric = (TECHNOLOGY == "GENERIC");

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [DBITS-1:0] dout_q;

  // Byte-lane write port
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BYTES; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[waddr_i][i*8 +: 8] <= din_i[i*8 +: 8];
      end
    end
  end

  // Registered read port; sees pre-write data on a same-cycle collision
  always_ff @(posedge clk_i) begin
    dout_q <= mem_q[raddr_i];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with configurable read wait states, byte-lane
// write-to-read forwarding and ERROR responses for bad addresses/sizes.
module ahb3lite_sram_ws
  import ahb3lite_pkg::*;
#(
  parameter int    MEM_SIZE         = 0,
  parameter int    MEM_DEPTH        = 256,
  parameter int    HADDR_SIZE       = 32,
  parameter int    HDATA_SIZE       = 32,
  parameter string TECHNOLOGY       = "GENERIC",
  parameter int    READ_WAIT_STATES = 0,
  parameter bit    ERROR_ON_OOR     = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP
);

  localparam int BE_SIZE    = HDATA_SIZE / 8;
  localparam int SIZE_DEPTH = 8 * MEM_SIZE / HDATA_SIZE;
  localparam int DEPTH      = (MEM_DEPTH > SIZE_DEPTH) ? MEM_DEPTH : SIZE_DEPTH;
  localparam int ABITS      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OFFS       = $clog2(BE_SIZE);

  // Burst type and protection carry no meaning for a plain memory
  logic unusedCtrl;
  assign unusedCtrl = ^{HBURST, HPROT};

  // State registers
  sram_state_e           state_q,   state_d;
  logic [ABITS-1:0]      addr_q,    addr_d;
  logic [BE_SIZE-1:0]    be_q,      be_d;
  logic [2:0]            waitCnt_q, waitCnt_d;
  logic [HDATA_SIZE-1:0] hrdata_q,  hrdata_d;
  logic [HDATA_SIZE-1:0] fwdData_q, fwdData_d;
  logic [BE_SIZE-1:0]    fwdBe_q,   fwdBe_d;
  logic                  fwdEn_q,   fwdEn_d;

  // Address-phase decode
  logic [HADDR_SIZE-1:0] haddrWordFull;
  logic [ABITS-1:0]      haddrWord;
  logic [31:0]           byteOffs;
  logic [BE_SIZE-1:0]    hbe;
  logic                  transValid;
  logic                  sizeErr;
  logic                  oorErr;
  logic                  addrErr;

  // FSM outputs and memory interface
  logic                  hreadyout;
  logic                  hresp;
  logic                  accept;
  sram_state_e           nextPhase;
  logic                  readyCycle;
  logic                  memWe;
  logic [ABITS-1:0]      memRaddr;
  logic [HDATA_SIZE-1:0] memDout;
  logic [HDATA_SIZE-1:0] mergedData;

  assign haddrWordFull = HADDR >> OFFS;
  assign haddrWord     = haddrWordFull[ABITS-1:0];
  assign byteOffs      = 32'(HADDR & HADDR_SIZE'(BE_SIZE - 1));
  assign hbe           = BE_SIZE'(gen_be(HSIZE, byteOffs));
  assign transValid    = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign sizeErr       = size_bytes(HSIZE) > BE_SIZE;
  assign oorErr        = ERROR_ON_OOR && (haddrWordFull >= HADDR_SIZE'(DEPTH));
  assign addrErr       = sizeErr || oorErr;

  // The final (ready) cycle of a read data phase
  assign readyCycle = (state_q == RDATA) && (waitCnt_q == 3'd0);

  // Next-state, response outputs, address-phase capture and buffer updates
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    waitCnt_d = waitCnt_q;
    hrdata_d  = hrdata_q;
    fwdData_d = fwdData_q;
    fwdBe_d   = fwdBe_q;
    fwdEn_d   = fwdEn_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    nextPhase = IDLE;

    case (state_q)
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ERR2:    hresp     = HRESP_ERROR;
      RDATA:   hreadyout = (waitCnt_q == 3'd0);
      default: ;
    endcase

    accept = HSEL && HREADY && hreadyout && transValid;

    if (accept) begin
      if (addrErr)     nextPhase = ERR1;
      else if (HWRITE) nextPhase = WDATA;
      else             nextPhase = RDATA;
      addr_d = haddrWord;
      be_d   = hbe;
    end

    if (accept && nextPhase == RDATA) begin
      waitCnt_d = 3'(READ_WAIT_STATES);
      fwdEn_d   = (state_q == WDATA) && (haddrWord == addr_q);
    end

    case (state_q)
      IDLE:  state_d = nextPhase;
      WDATA: if (HREADY) state_d = nextPhase;
      RDATA: begin
        if (waitCnt_q != 3'd0) waitCnt_d = waitCnt_q - 3'd1;
        else if (HREADY)       state_d   = nextPhase;
      end
      ERR1:    state_d = ERR2;
      ERR2:    if (HREADY) state_d = nextPhase;
      default: state_d = IDLE;
    endcase

    if (state_q == WDATA && HREADY) begin
      fwdData_d = HWDATA;
      fwdBe_d   = be_q;
    end

    if (readyCycle) begin
      hrdata_d = mergedData;
    end
  end

  // Register update with synchronous reset; reset abandons any data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      waitCnt_q <= 3'd0;
      hrdata_q  <= '0;
      fwdData_q <= '0;
      fwdBe_q   <= '0;
      fwdEn_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      waitCnt_q <= waitCnt_d;
      hrdata_q  <= hrdata_d;
      fwdData_q <= fwdData_d;
      fwdBe_q   <= fwdBe_d;
      fwdEn_q   <= fwdEn_d;
    end
  end

  // Overlay freshly written bytes on stale memory data for a colliding read
  always_comb begin
    mergedData = memDout;
    for (int i = 0; i < BE_SIZE; i++) begin
      if (fwdEn_q && fwdBe_q[i]) begin
        mergedData[i*8 +: 8] = fwdData_q[i*8 +: 8];
      end
    end
  end

  // A write commits on the edge that ends its data phase, unless reset aborts it.
  // With wait states the read address is held from the register so the macro
  // may take several cycles; otherwise it comes straight from the address phase.
  assign memWe    = (state_q == WDATA) && HREADY && !HRESET;
  assign memRaddr = ((READ_WAIT_STATES > 0) && (state_q == RDATA)) ? addr_q : haddrWord;

  rl_ram_1r1w #(
    .ABITS      (ABITS),
    .DBITS      (HDATA_SIZE),
    .TECHNOLOGY (TECHNOLOGY)
  ) u_ram (
    .clk_i   (HCLK),
    .waddr_i (addr_q),
    .we_i    (memWe),
    .be_i    (be_q),
    .din_i   (HWDATA),
    .raddr_i (memRaddr),
    .dout_o  (memDout)
  );

  assign HREADYOUT = hreadyout;
  assign HRESP     = hresp;
  assign HRDATA    = readyCycle ? mergedData : hrdata_q;

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Directed bench for ahb3lite_sram_ws: one zero-wait instance with range
// errors enabled, one three-wait-state instance with address wrapping.
module tb_ahb3lite_sram_ws;
  import ahb3lite_pkg::*;

  logic        clk;
  logic        hreset;
  logic        selA;
  logic        selB;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready;
  logic [31:0] rdataA;
  logic [31:0] rdataB;
  logic        readyA;
  logic        readyB;
  logic        respA;
  logic        respB;

  int checkCount = 0;
  int passCount  = 0;

  // Bus ready is the AND of both slaves; an idle slave always reports ready
  assign hready = readyA & readyB;

  ahb3lite_sram_ws #(
    .MEM_DEPTH        (256),
    .READ_WAIT_STATES (0),
    .ERROR_ON_OOR     (1)
  ) dutA (
    .HCLK      (clk),
    .HRESET    (hreset),
    .HSEL      (selA),
    .HADDR     (haddr),
    .HWDATA    (hwdata),
    .HRDATA    (rdataA),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HPROT     (hprot),
    .HTRANS    (htrans),
    .HREADYOUT (readyA),
    .HREADY    (hready),
    .HRESP     (respA)
  );

  ahb3lite_sram_ws #(
    .MEM_DEPTH        (256),
    .READ_WAIT_STATES (3),
    .ERROR_ON_OOR     (0)
  ) dutB (
    .HCLK      (clk),
    .HRESET    (hreset),
    .HSEL      (selB),
    .HADDR     (haddr),
    .HWDATA    (hwdata),
    .HRDATA    (rdataB),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HPROT     (hprot),
    .HTRANS    (htrans),
    .HREADYOUT (readyB),
    .HREADY    (hready),
    .HRESP     (respB)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck handshake still terminates the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    selA   = 1'b0;
    selB   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // Drive an address phase towards dutA (toB=0) or dutB (toB=1)
  task automatic applyStimulus(input bit toB, input bit wr, input logic [31:0] addr,
                               input logic [2:0] size);
    selA   = !toB;
    selB   = toB;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
  endtask

  // Complete write: address phase, then a zero-wait OKAY data phase
  task automatic writeXfer(input bit toB, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data);
    applyStimulus(toB, 1'b1, addr, size);
    step();
    idleBus();
    hwdata = data;
    checkOutput("write ready", toB ? readyB : readyA, 32'd1);
    checkOutput("write resp", toB ? respB : respA, 32'd0);
    step();
  endtask

  // Zero-wait read from dutA
  task automatic readA(input logic [31:0] addr, input logic [31:0] expected, input string tag);
    applyStimulus(1'b0, 1'b0, addr, HSIZE_WORD);
    step();
    idleBus();
    checkOutput({tag, " ready"}, readyA, 32'd1);
    checkOutput({tag, " data"}, rdataA, expected);
    step();
  endtask

  // Count dutB wait cycles of a read data phase already under way, then check data
  task automatic finishReadB(input logic [31:0] expected, input string tag);
    int lowCycles;
    lowCycles = 0;
    while (readyB === 1'b0 && lowCycles < 20) begin
      lowCycles++;
      step();
    end
    checkOutput({tag, " waits"}, lowCycles, 32'd3);
    checkOutput({tag, " data"}, rdataB, expected);
    step();
  endtask

  task automatic readB(input logic [31:0] addr, input logic [31:0] expected, input string tag);
    applyStimulus(1'b1, 1'b0, addr, HSIZE_WORD);
    step();
    idleBus();
    finishReadB(expected, tag);
  endtask

  // Write to dutA that must draw the two-cycle ERROR response
  task automatic errWriteA(input logic [31:0] addr, input logic [2:0] size, input string tag);
    applyStimulus(1'b0, 1'b1, addr, size);
    step();
    idleBus();
    hwdata = 32'h9999_9999;
    checkOutput({tag, " err1 ready"}, readyA, 32'd0);
    checkOutput({tag, " err1 resp"}, respA, 32'd1);
    step();
    checkOutput({tag, " err2 ready"}, readyA, 32'd1);
    checkOutput({tag, " err2 resp"}, respA, 32'd1);
    step();
    checkOutput({tag, " idle resp"}, respA, 32'd0);
  endtask

  // Directed sequence
  initial begin
    hreset = 1'b1;
    haddr  = '0;
    hwdata = '0;
    hsize  = HSIZE_WORD;
    hburst = 3'b000;
    hprot  = 4'b0011;
    idleBus();
    step();
    step();
    checkOutput("reset readyA", readyA, 32'd1);
    checkOutput("reset respA", respA, 32'd0);
    checkOutput("reset rdataA", rdataA, 32'd0);
    checkOutput("reset readyB", readyB, 32'd1);
    checkOutput("reset respB", respB, 32'd0);
    checkOutput("reset rdataB", rdataB, 32'd0);
    hreset = 1'b0;

    // Known contents for the error-path readbacks
    writeXfer(1'b0, 32'h00, HSIZE_WORD, 32'h0BAD_F00D);
    writeXfer(1'b0, 32'h08, HSIZE_WORD, 32'h1234_5678);

    // Word write immediately followed by a read of the same word
    applyStimulus(1'b0, 1'b1, 32'h10, HSIZE_WORD);
    step();
    hwdata = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 1'b0, 32'h10, HSIZE_WORD);
    checkOutput("t1 wdata ready", readyA, 32'd1);
    step();
    idleBus();
    checkOutput("t1 rdata ready", readyA, 32'd1);
    checkOutput("t1 rdata resp", respA, 32'd0);
    checkOutput("t1 rdata", rdataA, 32'hDEAD_BEEF);
    step();
    checkOutput("t1 hold", rdataA, 32'hDEAD_BEEF);
    readA(32'h10, 32'hDEAD_BEEF, "t1 readback");

    // Upper halfword write; low lanes of HWDATA carry junk that must be ignored
    writeXfer(1'b0, 32'h12, HSIZE_HWORD, 32'hCAFE_1357);
    readA(32'h10, 32'hCAFE_BEEF, "hword");

    // Byte write to lane 1 then an immediate read: forwarded with no stall
    writeXfer(1'b0, 32'h20, HSIZE_WORD, 32'h1122_3344);
    applyStimulus(1'b0, 1'b1, 32'h21, HSIZE_BYTE);
    step();
    hwdata = 32'h5A5A_AA5A;
    applyStimulus(1'b0, 1'b0, 32'h20, HSIZE_WORD);
    step();
    idleBus();
    checkOutput("t2 fwd ready", readyA, 32'd1);
    checkOutput("t2 fwd data", rdataA, 32'h1122_AA44);
    step();
    readA(32'h20, 32'h1122_AA44, "t2 memory");

    // Out-of-range write: ERROR and no wrap into word 0
    errWriteA(32'h400, HSIZE_WORD, "oor");
    readA(32'h00, 32'h0BAD_F00D, "oor readback");

    // Doubleword on a 32-bit bus: ERROR and no write
    errWriteA(32'h08, HSIZE_DWORD, "dword");
    readA(32'h08, 32'h1234_5678, "dword readback");

    // dutB: wrapping write to 0x400 lands in word 0 with an OKAY response
    writeXfer(1'b1, 32'h40, HSIZE_WORD, 32'h5566_7788);
    writeXfer(1'b1, 32'h400, HSIZE_WORD, 32'hA5A5_0400);

    // Three-wait read with a NONSEQ held pending during the waits
    applyStimulus(1'b1, 1'b0, 32'h40, HSIZE_WORD);
    step();
    haddr = 32'h00;
    for (int i = 0; i < 3; i++) begin
      checkOutput("ws3 wait", readyB, 32'd0);
      step();
    end
    checkOutput("ws3 ready", readyB, 32'd1);
    checkOutput("ws3 data", rdataB, 32'h5566_7788);
    step();
    idleBus();
    checkOutput("ws3 next accepted", readyB, 32'd0);
    checkOutput("ws3 hold", rdataB, 32'h5566_7788);
    finishReadB(32'hA5A5_0400, "wrap read");

    // Reset in the middle of a wait-state read
    applyStimulus(1'b1, 1'b0, 32'h40, HSIZE_WORD);
    step();
    idleBus();
    checkOutput("abort rd wait", readyB, 32'd0);
    step();
    hreset = 1'b1;
    step();
    checkOutput("abort rd ready", readyB, 32'd1);
    checkOutput("abort rd resp", respB, 32'd0);
    checkOutput("abort rd rdataB", rdataB, 32'd0);
    checkOutput("abort rd rdataA", rdataA, 32'd0);
    hreset = 1'b0;

    // Reset during a write data phase discards the write
    applyStimulus(1'b1, 1'b1, 32'h40, HSIZE_WORD);
    step();
    idleBus();
    hwdata = 32'hFFFF_FFFF;
    hreset = 1'b1;
    step();
    checkOutput("abort wr ready", readyB, 32'd1);
    checkOutput("abort wr resp", respB, 32'd0);
    checkOutput("abort wr rdata", rdataB, 32'd0);
    hreset = 1'b0;
    readB(32'h40, 32'h5566_7788, "abort wr readback");

    step();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
